mem_access_unit: RTL and testbench



---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage access unit: access sizes, FSM states
// and the request legality check used at accept time.
package mem_access_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  // Misaligned halves/words and the reserved size never touch memory.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-facing request/response bundle of the memory access unit.
// The pipeline MEM stage is the master; the access unit is the slave.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts/extends load data from a memory word and
// merges sub-word store data into the word read back for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves are only ever aligned here, so lane[1] alone picks the half.
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = word;
    case (size)
      SIZE_BYTE: load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:   load_ext = word;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;

      always_comb begin
        hit = 1'b0;
        src = wdata[7:0];
        case (size)
          SIZE_BYTE: begin
            hit = (lane == 2'(gi));
            src = wdata[7:0];
          end
          SIZE_HALF: begin
            hit = (lane[1] == 1'(gi / 2));
            src = wdata[(gi % 2) * 8 +: 8];
          end
          default: begin
            hit = 1'b1;
            src = wdata[gi * 8 +: 8];
          end
        endcase
      end

      assign store_merged[gi * 8 +: 8] = hit ? src : word[gi * 8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage initiator: one load/store at a time, read-modify-write for sub-word
// stores, extended load data returned with a one-cycle response pulse.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic              sig_mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_reg, state_next;
  logic [1:0]        lane_reg;
  logic [1:0]        size_reg;
  logic              sign_reg;
  logic              write_reg;
  logic              err_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic              accept;
  logic              accept_err;
  logic [DATA_W-1:0] align_word;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] store_merged;

  assign bus.req_ready = (state_reg == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign accept_err    = req_is_err(bus.req_size, bus.req_addr[1:0]);

  // RD merges against the live memory word; DONE extracts from the captured copy.
  assign align_word = (state_reg == S_RD) ? mem_rdata : word_q;

  mem_lane_align u_align (
    .word         (align_word),
    .lane         (lane_reg),
    .size         (size_reg),
    .sign_ext     (sign_reg),
    .wdata        (wdata_reg),
    .load_ext     (load_ext),
    .store_merged (store_merged)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (accept_err)
            state_next = S_DONE;
          else if (bus.req_write && bus.req_size == SIZE_WORD)
            state_next = S_WR;
          else
            state_next = S_RD;
        end
      end
      S_RD:    state_next = write_reg ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      lane_reg      <= '0;
      size_reg      <= '0;
      sign_reg      <= 1'b0;
      write_reg     <= 1'b0;
      err_reg       <= 1'b0;
      wdata_reg     <= '0;
      word_q        <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        lane_reg     <= bus.req_addr[1:0];
        size_reg     <= bus.req_size;
        sign_reg     <= bus.req_signed;
        write_reg    <= bus.req_write;
        err_reg      <= accept_err;
        wdata_reg    <= bus.req_wdata;
        mem_addr_reg <= {2'b00, bus.req_addr[ADDR_W-1:2]};
        if (bus.req_write && bus.req_size == SIZE_WORD && !accept_err)
          mem_wdata_reg <= bus.req_wdata;
      end
      if (state_reg == S_RD) begin
        word_q <= mem_rdata;
        if (write_reg)
          mem_wdata_reg <= store_merged;
      end
    end
  end

  assign sig_mem_write  = (state_reg == S_WR);
  assign mem_addr       = mem_addr_reg;
  assign mem_wdata      = mem_wdata_reg;
  assign bus.resp_valid = (state_reg == S_DONE);
  assign bus.resp_err   = (state_reg == S_DONE) && err_reg;
  assign bus.resp_rdata = (state_reg == S_DONE && !write_reg && !err_reg) ? load_ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of requests checked through a response scoreboard,
// plus hand sequences for store timing, read-modify-write, reset abort and back-to-back.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  logic        sig_mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .sig_mem_write (sig_mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Word-wide data memory model with combinational read.
  logic [31:0] mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_idx] <= pre_val;
    else if (sig_mem_write)
      mem[mem_addr[10:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[10:0]];

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          resp_count = 0;
  int          last_resp_cyc = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: memory writes and responses, responses checked against the scoreboard.
  always @(negedge clk) begin
    if (sig_mem_write) begin
      wr_count++;
      last_wr_cyc = cyc;
      last_wdata  = mem_wdata;
      last_waddr  = mem_addr;
    end
    if (bus.resp_valid) begin
      resp_count++;
      last_resp_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none", bus.resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic preload(input logic [10:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Presents a request, returns the cycle T whose closing edge accepted it.
  task automatic drive(input vec_t v, input logic push, output int t_acc);
    exp_t e;
    logic ok;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    ok      = 1'b0;
    t_acc   = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready) begin
        ok    = 1'b1;
        t_acc = cyc;
        if (push) sb.push_back(e);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept addr=%h", v.addr);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    sb.delete();
  endtask

  task automatic run_req(input vec_t v, output int t_acc);
    int wc0;
    int lat;
    int expw;
    wc0 = wr_count;
    drive(v, 1'b1, t_acc);
    wait_drain();
    if (v.exp_err)                         lat = 1;
    else if (v.wr && v.size != SIZE_WORD)  lat = 3;
    else                                   lat = 2;
    expw = (v.wr && !v.exp_err) ? 1 : 0;
    chk("resp_latency", 32'(last_resp_cyc - t_acc), 32'(lat));
    chk("write_count", 32'(wr_count - wc0), 32'(expw));
    $display("txn wr=%0d size=%0d sgn=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
             v.wr, v.size, v.sgn, v.addr, v.wdata, v.exp_rdata, v.exp_err);
  endtask

  function automatic vec_t mkv(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int t;
    int rc0;
    int wc0;
    int acc[3];
    int k;
    exp_t e;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Word 0x80FF7F01 at index 0x400, then zero word at 0x401 for store merges.
    tbl[0]  = mkv(0, SIZE_BYTE, 1, 32'h1002, 32'h0, 32'hFFFF_FFFF, 0);
    tbl[1]  = mkv(0, SIZE_BYTE, 0, 32'h1002, 32'h0, 32'h0000_00FF, 0);
    tbl[2]  = mkv(0, SIZE_HALF, 1, 32'h1002, 32'h0, 32'hFFFF_80FF, 0);
    tbl[3]  = mkv(0, SIZE_HALF, 0, 32'h1000, 32'h0, 32'h0000_7F01, 0);
    tbl[4]  = mkv(0, SIZE_BYTE, 1, 32'h1000, 32'h0, 32'h0000_0001, 0);
    tbl[5]  = mkv(0, SIZE_BYTE, 1, 32'h1003, 32'h0, 32'hFFFF_FF80, 0);
    tbl[6]  = mkv(0, SIZE_BYTE, 0, 32'h1001, 32'h0, 32'h0000_007F, 0);
    tbl[7]  = mkv(0, SIZE_HALF, 1, 32'h1000, 32'h0, 32'h0000_7F01, 0);
    tbl[8]  = mkv(0, SIZE_WORD, 1, 32'h1000, 32'h0, 32'h80FF_7F01, 0);
    tbl[9]  = mkv(1, SIZE_HALF, 0, 32'h1001, 32'h1234_5678, 32'h0, 1);
    tbl[10] = mkv(0, SIZE_WORD, 0, 32'h1002, 32'h0, 32'h0, 1);
    tbl[11] = mkv(0, 2'b11,     0, 32'h1000, 32'h0, 32'h0, 1);
    tbl[12] = mkv(0, SIZE_HALF, 1, 32'h1003, 32'h0, 32'h0, 1);
    tbl[13] = mkv(1, SIZE_BYTE, 0, 32'h1005, 32'h1234_565A, 32'h0, 0);
    tbl[14] = mkv(1, SIZE_HALF, 0, 32'h1006, 32'hCAFE_BEEF, 32'h0, 0);
    tbl[15] = mkv(0, SIZE_WORD, 0, 32'h1004, 32'h0, 32'hBEEF_5A00, 0);
    tbl[16] = mkv(0, SIZE_HALF, 1, 32'h1006, 32'h0, 32'hFFFF_BEEF, 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset_mem_write", {31'b0, sig_mem_write}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    preload(11'h400, 32'h80FF_7F01);
    preload(11'h401, 32'h0000_0000);
    preload(11'h402, 32'h1122_3344);

    for (int i = 0; i < 17; i++) run_req(tbl[i], t);

    // Word store then word load at 0x1000.
    run_req(mkv(1, SIZE_WORD, 0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0), t);
    chk("wstore_wr_cycle", 32'(last_wr_cyc), 32'(t + 1));
    chk("wstore_mem_addr", last_waddr, 32'h0000_0400);
    chk("wstore_mem_wdata", last_wdata, 32'hDEAD_BEEF);
    run_req(mkv(0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0), t);

    // Byte store into 0x11223344 goes RD then WR with the merged word.
    preload(11'h400, 32'h1122_3344);
    run_req(mkv(1, SIZE_BYTE, 0, 32'h1002, 32'h0000_00AB, 32'h0, 0), t);
    chk("rmw_wr_cycle", 32'(last_wr_cyc), 32'(t + 2));
    chk("rmw_mem_wdata", last_wdata, 32'h11AB_3344);
    run_req(mkv(0, SIZE_WORD, 0, 32'h1000, 32'h0, 32'h11AB_3344, 0), t);

    // Reset during WR of a sub-word store: no response for the aborted request.
    rc0 = resp_count;
    wc0 = wr_count;
    drive(mkv(1, SIZE_BYTE, 0, 32'h1008, 32'h0000_00CC, 32'h0, 0), 1'b0, t);
    chk("abort_accepted", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("abort_in_wr", {31'b0, sig_mem_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_write", {31'b0, sig_mem_write}, 32'd0);
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_resp", 32'(resp_count - rc0), 32'd0);
    chk("abort_write_count", 32'(wr_count - wc0), 32'd1);
    $display("txn abort byte store addr=00001008 reset during WR");

    // req_valid held high across three word loads.
    rc0 = resp_count;
    k = 0;
    e.rdata = 32'h11AB_3344;
    e.err   = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h1000;
    bus.req_wdata  = '0;
    for (int n = 0; n < 40; n++) begin
      if (bus.req_ready) begin
        acc[k] = cyc;
        sb.push_back(e);
        k++;
        if (k == 3) break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("held_accepts", 32'(k), 32'd3);
    if (k == 3) begin
      chk("held_spacing_0", 32'(acc[1] - acc[0]), 32'd3);
      chk("held_spacing_1", 32'(acc[2] - acc[1]), 32'd3);
    end
    wait_drain();
    repeat (4) @(negedge clk);
    chk("held_resp_count", 32'(resp_count - rc0), 32'd3);
    $display("txn held_valid three word loads addr=00001000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

endmodule
